// File: rtl/am_key_receiver.sv
// am_key_receiver
//
// Receive side of the key-leak AM channel. The antenna line is brought into
// the clock domain, every level change is treated as one carrier edge, and
// each BIT_CYCLES-long window is decoded as 1 when it holds at least
// EDGE_THRESH edges. A frame is one start window (must carry the carrier),
// KEY_W data windows sent MSB first, then a silence gap of GAP_CYCLES
// edge-free cycles before another frame may start.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   Antena     asynchronous antenna/carrier input
//   key_out    last key received without a framing error (MSB = first data bit)
//   key_valid  one-cycle pulse in the cycle key_out takes a new frame's key
//   frame_err  one-cycle pulse when the start window lacks carrier
//   busy       high while a frame or its trailing gap is in progress
module am_key_receiver #(
    parameter int KEY_W       = 128,
    parameter int BIT_CYCLES  = 64,
    parameter int EDGE_THRESH = 8,
    parameter int GAP_CYCLES  = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Antena,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int WIN_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int CNT_W = $clog2(BIT_CYCLES + 1);
    localparam int BIT_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(BIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_THRESH = CNT_W'(EDGE_THRESH);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(KEY_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_GAP
    } state_t;

    // Edge counter increment that sticks at BIT_CYCLES instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             inc);
        if (inc && (cnt != CNT_MAX)) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

    // Stage p0/p1: two-flop synchronizer; p2: one cycle of history for edge detect.
    // Left without reset so the edge stream depends on the antenna alone.
    logic ant_p0;
    logic ant_p1;
    logic ant_p2;

    always_ff @(posedge clk) begin
        ant_p0 <= Antena;
        ant_p1 <= ant_p0;
        ant_p2 <= ant_p1;
    end

    logic edge_det;
    assign edge_det = ant_p1 ^ ant_p2;

    // Framing state and counters.
    state_t           state;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [KEY_W-1:0] shift_reg;

    // Window totals include the edge arriving on the window's last cycle.
    logic [CNT_W-1:0] cnt_total;
    logic             win_end;
    logic             win_bit;

    assign cnt_total = sat_inc(edge_cnt, edge_det);
    assign win_end   = (win_cnt == WIN_LAST);
    assign win_bit   = (cnt_total >= CNT_THRESH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            win_cnt   <= '0;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            shift_reg <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    win_cnt  <= '0;
                    edge_cnt <= '0;
                    // The triggering edge is window cycle 0 and the first edge counted.
                    if (edge_det) begin
                        state     <= S_START;
                        win_cnt   <= WIN_W'(1);
                        edge_cnt  <= CNT_W'(1);
                        shift_reg <= '0;
                        busy      <= 1'b1;
                    end
                end

                S_START: begin
                    edge_cnt <= cnt_total;
                    win_cnt  <= win_cnt + 1'b1;
                    if (win_end) begin
                        win_cnt  <= '0;
                        edge_cnt <= '0;
                        bit_cnt  <= '0;
                        if (win_bit) begin
                            state <= S_DATA;
                        end else begin
                            state     <= S_IDLE;
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end

                S_DATA: begin
                    edge_cnt <= cnt_total;
                    win_cnt  <= win_cnt + 1'b1;
                    if (win_end) begin
                        win_cnt   <= '0;
                        edge_cnt  <= '0;
                        // The cast drops the bit shifted out of the top.
                        shift_reg <= KEY_W'({shift_reg, win_bit});
                        if (bit_cnt == BIT_LAST) begin
                            key_out   <= KEY_W'({shift_reg, win_bit});
                            key_valid <= 1'b1;
                            gap_cnt   <= '0;
                            state     <= S_GAP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                S_GAP: begin
                    // Carrier during the gap restarts the silence count rather than a frame.
                    if (edge_det) begin
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_am_key_receiver.sv
`timescale 1ns/1ps
module tb_am_key_receiver;

    localparam int KW   = 128;
    localparam int BC   = 64;
    localparam int TH   = 8;
    localparam int GC   = 256;
    localparam int MAXC = 90000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          Antena = 1'b0;
    logic [KW-1:0] key_out;
    logic          key_valid;
    logic          frame_err;
    logic          busy;

    am_key_receiver #(
        .KEY_W      (KW),
        .BIT_CYCLES (BC),
        .EDGE_THRESH(TH),
        .GAP_CYCLES (GC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Antena   (Antena),
        .key_out  (key_out),
        .key_valid(key_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            c;
        logic [KW-1:0] k;
    } ev_t;

    typedef struct {
        bit            is_err;
        logic [KW-1:0] key;
        int            style;
        int            exp_valid;
        int            exp_err;
        logic [KW-1:0] exp_key;
    } row_t;

    int vectors = 0;
    int miscompares = 0;

    // Per-cycle record of what the DUT saw and produced; index = rising edge number.
    int  cyc = 0;
    bit  a_hist [MAXC];
    bit  r_hist [MAXC];
    bit  b_hist [MAXC];
    bit  exp_busy [MAXC];
    ev_t obs_valid[$];
    ev_t obs_keychg[$];
    int  obs_err[$];
    ev_t exp_valid[$];
    ev_t exp_keychg[$];
    int  exp_err[$];

    logic [KW-1:0] prev_key = '0;
    bit            ant_lvl = 1'b0;
    int            n_valid = 0;
    int            n_err = 0;
    int            last_valid_c = -1;
    int            last_err_c = -1;
    int            idle_bad = 0;

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_key(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, record what the DUT samples, then observe outputs.
    task automatic tick(input bit r);
        ev_t ev;
        rst    = r;
        Antena = ant_lvl;
        @(posedge clk);
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: reached %0d cycles, limit %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        a_hist[cyc] = ant_lvl;
        r_hist[cyc] = r;
        #1;
        b_hist[cyc] = busy;
        if (key_valid) begin
            ev.c = cyc; ev.k = key_out;
            obs_valid.push_back(ev);
            n_valid++;
            last_valid_c = cyc;
        end
        if (frame_err) begin
            obs_err.push_back(cyc);
            n_err++;
            last_err_c = cyc;
        end
        if (key_out !== prev_key) begin
            ev.c = cyc; ev.k = key_out;
            obs_keychg.push_back(ev);
            prev_key = key_out;
        end
        cyc++;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    // Mask bit i set = toggle the antenna on window cycle i.
    task automatic send_window(input logic [BC-1:0] m);
        for (int i = 0; i < BC; i++) begin
            if (m[i]) ant_lvl = ~ant_lvl;
            tick(1'b0);
        end
    endtask

    function automatic logic [BC-1:0] even_mask();
        logic [BC-1:0] m = '0;
        for (int i = 0; i < BC; i += 2) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [BC-1:0] spaced(input int first, input int step, input int n, input bit last);
        logic [BC-1:0] m = '0;
        for (int i = 0; i < n; i++) m[first + i * step] = 1'b1;
        if (last) m[BC-1] = 1'b1;
        return m;
    endfunction

    function automatic logic [BC-1:0] rand_mask(input int n, input bit at0);
        logic [BC-1:0] m = '0;
        int cnt = 0;
        int p;
        if (at0) begin m[0] = 1'b1; cnt = 1; end
        while (cnt < n) begin
            p = int'($urandom_range(BC - 1, 0));
            if (!m[p]) begin m[p] = 1'b1; cnt++; end
        end
        return m;
    endfunction

    // style 0: dense carrier; 1: exactly TH / TH-1 edges with one edge on the
    // first or last window cycle; 2: random edge counts on each side of TH.
    function automatic logic [BC-1:0] data_mask(input bit b, input int style, input int k);
        if (style == 0) return b ? even_mask() : '0;
        if (style == 1) begin
            if (b) return (k % 2 == 1) ? spaced(0, 5, TH, 0) : spaced(10, 5, TH - 1, 1);
            return (k % 4 < 2) ? spaced(0, 5, TH - 1, 0) : spaced(10, 5, TH - 2, 1);
        end
        if (b) return rand_mask(int'($urandom_range(40, TH)), 1'b0);
        return rand_mask(int'($urandom_range(TH - 1, 0)), 1'b0);
    endfunction

    task automatic send_frame(input logic [KW-1:0] key, input int style);
        if (style == 2) send_window(rand_mask(int'($urandom_range(40, TH)), 1'b1));
        else            send_window(even_mask());
        for (int k = 0; k < KW; k++) send_window(data_mask(key[KW-1-k], style, k));
    endtask

    // ---------------- reference model over the recorded stimulus ----------------
    function automatic bit e_at(input int c);
        if (c < 3) return 1'b0;
        return a_hist[c-2] ^ a_hist[c-3];
    endfunction

    function automatic int first_rst(input int s, input int e);
        for (int i = s; i <= e && i < cyc; i++) if (r_hist[i]) return i;
        return -1;
    endfunction

    function automatic int edges_in(input int s);
        int n = 0;
        for (int i = s; i < s + BC && i < cyc; i++) n += int'(e_at(i));
        return n;
    endfunction

    task automatic mark_busy(input int s, input int e);
        for (int i = s; i <= e && i < cyc; i++) exp_busy[i] = 1'b1;
    endtask

    task automatic run_model();
        int c, c0, rr, ws, vc, j, run, vi, n;
        bit aborted, gap_done;
        logic [KW-1:0] key, cur, nk;
        ev_t ev;
        n = cyc;
        c = 0;
        for (int i = 0; i < n; i++) exp_busy[i] = 1'b0;
        while (c < n) begin
            if (r_hist[c] || !e_at(c)) begin
                c++;
            end else begin
                c0 = c;
                rr = first_rst(c0, c0 + BC - 1);
                if (rr >= 0) begin
                    mark_busy(c0, rr - 1);
                    c = rr;
                end else if (edges_in(c0) < TH) begin
                    exp_err.push_back(c0 + BC - 1);
                    mark_busy(c0, c0 + BC - 2);
                    c = c0 + BC;
                end else begin
                    aborted = 1'b0;
                    key = '0;
                    for (int k = 0; k < KW && !aborted; k++) begin
                        ws = c0 + BC * (k + 1);
                        rr = first_rst(ws, ws + BC - 1);
                        if (rr >= 0) begin
                            mark_busy(c0, rr - 1);
                            c = rr;
                            aborted = 1'b1;
                        end else begin
                            key[KW-1-k] = (edges_in(ws) >= TH);
                        end
                    end
                    if (!aborted) begin
                        vc = c0 + BC * (KW + 1) - 1;
                        ev.c = vc; ev.k = key;
                        exp_valid.push_back(ev);
                        j = vc + 1;
                        run = 0;
                        gap_done = 1'b0;
                        while (j < n && !gap_done && !r_hist[j]) begin
                            run = e_at(j) ? 0 : run + 1;
                            gap_done = (run == GC);
                            j++;
                        end
                        if (gap_done) mark_busy(c0, j - 2);
                        else          mark_busy(c0, j - 1);
                        c = j;
                    end
                end
            end
        end
        cur = '0;
        vi = 0;
        for (int i = 0; i < n; i++) begin
            nk = cur;
            if (r_hist[i]) nk = '0;
            else if (vi < exp_valid.size() && exp_valid[vi].c == i) nk = exp_valid[vi].k;
            while (vi < exp_valid.size() && exp_valid[vi].c <= i) vi++;
            if (nk !== cur) begin
                ev.c = i; ev.k = nk;
                exp_keychg.push_back(ev);
                cur = nk;
            end
        end
    endtask

    task automatic compare_model();
        int bad = 0;
        int first = -1;
        chk_int("model_valid_count", obs_valid.size(), exp_valid.size());
        for (int i = 0; i < obs_valid.size() && i < exp_valid.size(); i++) begin
            chk_int($sformatf("model_valid_cycle[%0d]", i), obs_valid[i].c, exp_valid[i].c);
            chk_key($sformatf("model_valid_key[%0d]", i), obs_valid[i].k, exp_valid[i].k);
        end
        chk_int("model_err_count", obs_err.size(), exp_err.size());
        for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++)
            chk_int($sformatf("model_err_cycle[%0d]", i), obs_err[i], exp_err[i]);
        chk_int("model_keychg_count", obs_keychg.size(), exp_keychg.size());
        for (int i = 0; i < obs_keychg.size() && i < exp_keychg.size(); i++) begin
            chk_int($sformatf("model_keychg_cycle[%0d]", i), obs_keychg[i].c, exp_keychg[i].c);
            chk_key($sformatf("model_keychg_key[%0d]", i), obs_keychg[i].k, exp_keychg[i].k);
        end
        for (int i = 0; i < cyc; i++) begin
            if (b_hist[i] != exp_busy[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        chk_int($sformatf("busy_trace_mismatches(first at %0d)", first), bad, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit hit at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        row_t          rows [5];
        logic [KW-1:0] k1, k2, k3, kr;
        int            v0, e0, f;

        k1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
        k2 = 128'hA5C3_0F96_3C5A_E187_55AA_00FF_1234_8001;
        k3 = 128'hDEADBEEF_CAFEF00D_0BADC0DE_13579BDF;

        rows[0] = '{1'b0, k1,          0, 1, 0, k1};
        rows[1] = '{1'b0, '0,          0, 1, 0, '0};
        rows[2] = '{1'b0, {KW{1'b1}},  0, 1, 0, {KW{1'b1}}};
        rows[3] = '{1'b1, '0,          0, 0, 1, {KW{1'b1}}};
        rows[4] = '{1'b0, k2,          1, 1, 0, k2};

        // Reset state.
        for (int i = 0; i < 5; i++) tick(1'b1);
        chk_key("reset_key_out", key_out, '0);
        chk_int("reset_key_valid", int'(key_valid), 0);
        chk_int("reset_frame_err", int'(frame_err), 0);
        chk_int("reset_busy", int'(busy), 0);

        // Silent line: nothing may happen.
        for (int i = 0; i < 1000; i++) begin
            tick(1'b0);
            if (key_valid || frame_err || busy || (key_out != '0)) idle_bad++;
        end
        chk_int("idle_silent_cycles_with_activity", idle_bad, 0);

        // Table of whole frames.
        for (int i = 0; i < 5; i++) begin
            v0 = n_valid;
            e0 = n_err;
            f  = cyc;
            if (rows[i].is_err) send_window(spaced(0, 10, 4, 1'b0));
            else                send_frame(rows[i].key, rows[i].style);
            quiet(300);
            chk_int($sformatf("row%0d_valid_pulses", i), n_valid - v0, rows[i].exp_valid);
            chk_int($sformatf("row%0d_err_pulses", i), n_err - e0, rows[i].exp_err);
            chk_key($sformatf("row%0d_key_out", i), key_out, rows[i].exp_key);
            chk_int($sformatf("row%0d_busy_after", i), int'(busy), 0);
            if (rows[i].exp_valid != 0)
                chk_int($sformatf("row%0d_valid_latency", i), last_valid_c - (f + 1), (KW + 1) * BC);
            if (rows[i].exp_err != 0)
                chk_int($sformatf("row%0d_err_latency", i), last_err_c - (f + 1), BC);
        end

        // Reset in the middle of data bit 60.
        v0 = n_valid;
        send_window(even_mask());
        for (int k = 0; k < 60; k++) send_window(data_mask(k3[KW-1-k], 0, k));
        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) ant_lvl = ~ant_lvl;
            tick(1'b0);
        end
        quiet(4);
        tick(1'b1);
        chk_key("midframe_rst_key_out", key_out, '0);
        chk_int("midframe_rst_busy", int'(busy), 0);
        chk_int("midframe_rst_key_valid", int'(key_valid), 0);
        quiet(10);
        chk_int("midframe_rst_no_valid", n_valid - v0, 0);
        f = cyc;
        send_frame(k3, 0);
        quiet(100);
        chk_key("after_rst_frame_key", key_out, k3);
        chk_int("after_rst_frame_latency", last_valid_c - (f + 1), (KW + 1) * BC);

        // Carrier during the gap only stretches it.
        v0 = n_valid;
        e0 = n_err;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) ant_lvl = ~ant_lvl;
            tick(1'b0);
        end
        quiet(200);
        chk_int("gap_extended_busy", int'(busy), 1);
        quiet(100);
        chk_int("gap_released_busy", int'(busy), 0);
        chk_int("gap_edges_no_valid", n_valid - v0, 0);
        chk_int("gap_edges_no_err", n_err - e0, 0);

        // Randomized frames.
        for (int r = 0; r < 2; r++) begin
            kr = {$urandom, $urandom, $urandom, $urandom};
            send_frame(kr, 2);
            quiet(300);
            chk_key($sformatf("random_frame%0d_key", r), key_out, kr);
        end

        run_model();
        compare_model();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
